altera_tse_reset_ctrl_lego: RTL and testbench

ALTERA_TSE_RESET_CTRL_LEGO -- requirements
Module: altera_tse_reset_ctrl_lego

---
 rtl/altera_tse_xcvr_resync.sv | 24 ++
 rtl/altera_tse_reset_ctrl_lego.sv | 91 +++++++++
 tb/tb_altera_tse_reset_ctrl_lego.sv | 137 +++++++++++++
 3 files changed

// File: rtl/altera_tse_xcvr_resync.sv
`timescale 1ns/1ps
// Multi-bit resynchronizer: each bit of d passes through its own flop chain,
// so q is d delayed by SYNC_CHAIN_LENGTH clocks. No reset; flops power up to INIT_VALUE.
module altera_tse_xcvr_resync #(
  parameter int WIDTH             = 1,
  parameter int SYNC_CHAIN_LENGTH = 2,
  parameter int INIT_VALUE        = 0
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  localparam int LEN = (SYNC_CHAIN_LENGTH < 2) ? 2 : SYNC_CHAIN_LENGTH;
  localparam logic [WIDTH-1:0] INIT_VEC = (INIT_VALUE != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [LEN-1:0][WIDTH-1:0] r_chain = {LEN{INIT_VEC}};

  // Shift chain: stage 0 captures d, the last stage drives q.
  always_ff @(posedge clk) begin
    r_chain <= {r_chain[LEN-2:0], d};
  end

  assign q = r_chain[LEN-1];
endmodule

// File: rtl/altera_tse_reset_ctrl_lego.sv
`timescale 1ns/1ps
// Reset sequencer: holds reset for a minimum pulse (optionally until rdone),
// then raises sdone once rdone has stayed high for a programmable delay.
module altera_tse_reset_ctrl_lego #(
  parameter int reset_hold_til_rdone = 0,
  parameter int reset_hold_cycles    = 1,
  parameter int sdone_delay_cycles   = 0
) (
  input  logic clock,
  input  logic aclr,
  input  logic start,
  input  logic rdone,
  output logic reset,
  output logic sdone
);
  localparam int HOLD_W  = (reset_hold_cycles  < 1) ? 1 : $clog2(reset_hold_cycles + 1);
  localparam int DELAY_W = (sdone_delay_cycles < 1) ? 1 : $clog2(sdone_delay_cycles + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(reset_hold_cycles);
  localparam logic [DELAY_W-1:0] DELAY_MAX = DELAY_W'(sdone_delay_cycles);
  localparam logic TIL_RDONE = (reset_hold_til_rdone != 0);

  logic               r_reset = 1'b1;
  logic               r_sdone = 1'b0;
  logic [HOLD_W-1:0]  r_hold  = {HOLD_W{1'b0}};
  logic [DELAY_W-1:0] r_delay = {DELAY_W{1'b0}};

  logic               w_reset_nxt;
  logic               w_sdone_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [DELAY_W-1:0] w_delay_nxt;
  logic               w_hold_done;
  logic               w_release;

  // Next-state: start restarts, hold phase counts up, then rdone qualifies sdone.
  always_comb begin
    w_reset_nxt = r_reset;
    w_sdone_nxt = r_sdone;
    w_hold_nxt  = r_hold;
    w_delay_nxt = r_delay;
    w_hold_done = (r_hold == HOLD_MAX);
    w_release   = w_hold_done && (!TIL_RDONE || rdone);
    if (start) begin
      w_reset_nxt = 1'b1;
      w_sdone_nxt = 1'b0;
      w_hold_nxt  = {HOLD_W{1'b0}};
      w_delay_nxt = {DELAY_W{1'b0}};
    end else if (r_reset) begin
      w_sdone_nxt = 1'b0;
      w_delay_nxt = {DELAY_W{1'b0}};
      if (!w_hold_done) begin
        w_hold_nxt = r_hold + HOLD_W'(1'b1);
      end else begin
        w_hold_nxt = r_hold;
      end
      if (w_release) begin
        w_reset_nxt = 1'b0;
      end else begin
        w_reset_nxt = 1'b1;
      end
    end else if (rdone) begin
      // Delay saturates at its maximum; sdone only rises once it is already there.
      if (r_delay != DELAY_MAX) begin
        w_delay_nxt = r_delay + DELAY_W'(1'b1);
      end else begin
        w_delay_nxt = r_delay;
      end
      w_sdone_nxt = (r_delay == DELAY_MAX);
    end else begin
      w_delay_nxt = {DELAY_W{1'b0}};
      w_sdone_nxt = 1'b0;
    end
  end

  // State registers; aclr overrides everything including start.
  always_ff @(posedge clock) begin
    if (aclr) begin
      r_reset <= 1'b1;
      r_sdone <= 1'b0;
      r_hold  <= {HOLD_W{1'b0}};
      r_delay <= {DELAY_W{1'b0}};
    end else begin
      r_reset <= w_reset_nxt;
      r_sdone <= w_sdone_nxt;
      r_hold  <= w_hold_nxt;
      r_delay <= w_delay_nxt;
    end
  end

  assign reset = r_reset;
  assign sdone = r_sdone;
endmodule

// File: tb/tb_altera_tse_reset_ctrl_lego.sv
`timescale 1ns/1ps
// Scoreboard bench: three parameterisations of the reset sequencer plus a 4-bit resync,
// all compared each cycle against a run-length reference model.
module tb_altera_tse_reset_ctrl_lego;
  localparam int H0 = 3, D0 = 0, T0 = 0;
  localparam int H1 = 1, D1 = 0, T1 = 1;
  localparam int H2 = 2, D2 = 8, T2 = 0;

  logic       clock = 1'b0;
  logic       aclr  = 1'b1;
  logic       start = 1'b0;
  logic       rdone = 1'b0;
  logic [3:0] rs_d  = 4'h0;
  logic [2:0] dut_reset;
  logic [2:0] dut_sdone;
  logic [3:0] rs_q;

  always #5 clock = ~clock;

  altera_tse_reset_ctrl_lego #(.reset_hold_til_rdone(T0), .reset_hold_cycles(H0), .sdone_delay_cycles(D0)) u_dut0 (
    .clock(clock), .aclr(aclr), .start(start), .rdone(rdone), .reset(dut_reset[0]), .sdone(dut_sdone[0]));
  altera_tse_reset_ctrl_lego #(.reset_hold_til_rdone(T1), .reset_hold_cycles(H1), .sdone_delay_cycles(D1)) u_dut1 (
    .clock(clock), .aclr(aclr), .start(start), .rdone(rdone), .reset(dut_reset[1]), .sdone(dut_sdone[1]));
  altera_tse_reset_ctrl_lego #(.reset_hold_til_rdone(T2), .reset_hold_cycles(H2), .sdone_delay_cycles(D2)) u_dut2 (
    .clock(clock), .aclr(aclr), .start(start), .rdone(rdone), .reset(dut_reset[2]), .sdone(dut_sdone[2]));
  altera_tse_xcvr_resync #(.WIDTH(4), .SYNC_CHAIN_LENGTH(2), .INIT_VALUE(0)) u_rs (
    .clk(clock), .d(rs_d), .q(rs_q));

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  int   cfg_h[3] = '{H0, H1, H2};
  int   cfg_d[3] = '{D0, D1, D2};
  int   cfg_t[3] = '{T0, T1, T2};
  logic m_reset[3] = '{1'b1, 1'b1, 1'b1};
  logic m_sdone[3] = '{1'b0, 1'b0, 1'b0};
  int   m_elapsed[3] = '{0, 0, 0};
  int   m_run[3] = '{0, 0, 0};
  logic [3:0] m_d1 = 4'h0;
  logic [3:0] m_d2 = 4'h0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: reset releases once H non-start edges have elapsed (and rdone if required);
  // sdone is high once rdone has been seen on more than D consecutive edges with reset low.
  task automatic model_step(input logic a, input logic s, input logic rd, input logic [3:0] d);
    for (int k = 0; k < 3; k++) begin
      if (a || s) begin
        m_reset[k] = 1'b1; m_sdone[k] = 1'b0; m_elapsed[k] = 0; m_run[k] = 0;
      end else if (m_reset[k]) begin
        m_sdone[k] = 1'b0;
        if (m_elapsed[k] >= cfg_h[k] && (cfg_t[k] == 0 || rd)) begin
          m_reset[k] = 1'b0; m_run[k] = 0;
        end else begin
          m_elapsed[k]++;
        end
      end else begin
        m_run[k] = rd ? m_run[k] + 1 : 0;
        m_sdone[k] = (m_run[k] > cfg_d[k]);
      end
    end
    m_d2 = m_d1;
    m_d1 = d;
  endtask

  task automatic cyc(input logic a, input logic s, input logic rd);
    logic [9:0] e;
    aclr = a; start = s; rdone = rd; rs_d = 4'($urandom);
    model_step(a, s, rd, rs_d);
    for (int k = 0; k < 3; k++) begin
      e[k] = m_reset[k];
      e[3+k] = m_sdone[k];
    end
    e[9:6] = m_d2;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: power-up values, then one popped expectation per cycle.
  initial begin
    logic [9:0] e;
    #1;
    check("powerup_reset", {1'b0, dut_reset}, 4'h7);
    check("powerup_sdone", {1'b0, dut_sdone}, 4'h0);
    check("powerup_rsq", rs_q, 4'h0);
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          check($sformatf("dut%0d_reset", k), {3'b000, dut_reset[k]}, {3'b000, e[k]});
          check($sformatf("dut%0d_sdone", k), {3'b000, dut_sdone[k]}, {3'b000, e[3+k]});
        end
        check("resync_q", rs_q, e[9:6]);
      end
    end
  end

  // Driver: directed sequences first, then biased random traffic.
  initial begin
    logic rd;
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    repeat (15) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (15) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (15) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0, 1'b1);
    rd = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) rd = ~rd;
      cyc($urandom_range(99) == 0, $urandom_range(31) == 0, rd);
    end
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
